// File: rtl/spi_word_assembler.sv
// Collects NBYTES received SPI bytes into one word and exposes the raw word plus an
// extracted field. Completed frames are held until the consumer acknowledges them.
module spi_word_assembler #(
    parameter int NBYTES    = 2,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    input  logic                  ack_i,
    input  logic                  clr_ovr_i,
    output logic [8*NBYTES-1:0]   raw_o,
    output logic [OUT_W-1:0]      word_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic [2:0]            count_o,
    output logic                  overrun_o
);

    localparam int W = 8 * NBYTES;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [2:0] LAST = 3'(NBYTES - 1);
    localparam logic [2:0] FULL = 3'(NBYTES);

    generate
        if ((SHIFT + OUT_W > W) || (NBYTES < 1) || (NBYTES > 4)) begin : g_bad_params
            $error("spi_word_assembler: field [SHIFT+OUT_W-1:SHIFT] must fit in 8*NBYTES bits, NBYTES in 1..4");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [W-1:0]     asm_q, asm_d, asm_ins;
    logic [W-1:0]     raw_q, raw_d;
    logic [OUT_W-1:0] word_q, word_d;
    logic             ovr_q, ovr_d;

    // Assembly word with the incoming byte dropped into the slot selected by count.
    always_comb begin
        asm_ins = asm_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (count_q == 3'(i)) begin
                asm_ins[8*((MSB_FIRST != 0) ? (NBYTES - 1 - i) : i) +: 8] = byte_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        asm_d   = asm_q;
        raw_d   = raw_q;
        word_d  = word_q;
        ovr_d   = clr_ovr_i ? 1'b0 : ovr_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COLLECT;
                    count_d = 3'd0;
                    asm_d   = '0;
                end
            end
            COLLECT: begin
                if (start_i) begin
                    count_d = 3'd0;
                    asm_d   = '0;
                end else if (byte_valid_i) begin
                    if (count_q == LAST) begin
                        state_d = DONE;
                        count_d = 3'd0;
                        asm_d   = '0;
                        raw_d   = asm_ins;
                        word_d  = asm_ins[SHIFT +: OUT_W];
                    end else begin
                        asm_d   = asm_ins;
                        count_d = count_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (ack_i) begin
                    state_d = start_i ? COLLECT : IDLE;
                    count_d = 3'd0;
                    asm_d   = '0;
                end else if (byte_valid_i) begin
                    // The pending frame is kept; the late byte is lost and flagged.
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
                asm_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            asm_q   <= '0;
            raw_q   <= '0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            asm_q   <= asm_d;
            raw_q   <= raw_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
        end
    end

    assign raw_o     = raw_q;
    assign word_o    = word_q;
    assign valid_o   = (state_q == DONE);
    assign busy_o    = (state_q == COLLECT);
    assign count_o   = (state_q == DONE) ? FULL : ((state_q == COLLECT) ? count_q : 3'd0);
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// Directed bench: a vector table drives the default-parameter assembler, and a
// hand-written sequence checks a 3-byte LSB-first instance sharing the same inputs.
module tb_spi_word_assembler;

    logic        clk = 1'b0;
    logic        reset, start, byteValid, ack, clrOvr;
    logic [7:0]  byteIn;

    logic [15:0] raw;
    logic [7:0]  word;
    logic        valid, busy, overrun;
    logic [2:0]  count;

    logic [23:0] raw3;
    logic [11:0] word3;
    logic        valid3, busy3, overrun3;
    logic [2:0]  count3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_word_assembler dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .byte_valid_i(byteValid),
        .byte_i(byteIn), .ack_i(ack), .clr_ovr_i(clrOvr),
        .raw_o(raw), .word_o(word), .valid_o(valid), .busy_o(busy),
        .count_o(count), .overrun_o(overrun)
    );

    spi_word_assembler #(.NBYTES(3), .OUT_W(12), .SHIFT(0), .MSB_FIRST(0)) dut3 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .byte_valid_i(byteValid),
        .byte_i(byteIn), .ack_i(ack), .clr_ovr_i(clrOvr),
        .raw_o(raw3), .word_o(word3), .valid_o(valid3), .busy_o(busy3),
        .count_o(count3), .overrun_o(overrun3)
    );

    typedef struct {
        logic        rst, st, bv;
        logic [7:0]  b;
        logic        ak, clr;
        logic [15:0] expRaw;
        logic [7:0]  expWord;
        logic        expValid, expBusy;
        logic [2:0]  expCount;
        logic        expOvr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rst, st, bv, input logic [7:0] b, input logic ak, clr,
                          input logic [15:0] r, input logic [7:0] w,
                          input logic v, bz, input logic [2:0] c, input logic o);
        vec_t x;
        x.rst = rst; x.st = st; x.bv = bv; x.b = b; x.ak = ak; x.clr = clr;
        x.expRaw = r; x.expWord = w; x.expValid = v; x.expBusy = bz;
        x.expCount = c; x.expOvr = o;
        vecs.push_back(x);
    endtask

    // Drive one cycle of inputs, then let outputs settle past the active edge.
    task automatic applyStimulus(input logic rst, st, bv, input logic [7:0] b, input logic ak, clr);
        reset = rst; start = st; byteValid = bv; byteIn = b; ack = ak; clrOvr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] r, input logic [7:0] w,
                               input logic v, bz, input logic [2:0] c, input logic o);
        checks++;
        if ({raw, word, valid, busy, count, overrun} !== {r, w, v, bz, c, o}) begin
            errors++;
            $display("[TB] FAIL %s: got raw=%h word=%h valid=%b busy=%b count=%0d ovr=%b, expected raw=%h word=%h valid=%b busy=%b count=%0d ovr=%b",
                     name, raw, word, valid, busy, count, overrun, r, w, v, bz, c, o);
        end
    endtask

    task automatic checkWide(input string name, input logic [23:0] r, input logic [11:0] w,
                             input logic v, bz, input logic [2:0] c);
        checks++;
        if ({raw3, word3, valid3, busy3, count3} !== {r, w, v, bz, c}) begin
            errors++;
            $display("[TB] FAIL %s: got raw=%h word=%h valid=%b busy=%b count=%0d, expected raw=%h word=%h valid=%b busy=%b count=%0d",
                     name, raw3, word3, valid3, busy3, count3, r, w, v, bz, c);
        end
    endtask

    initial begin
        //     rst st bv byte   ak clr   raw       word   v  bz cnt ovr
        addVec(1, 0, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 0 reset
        addVec(0, 0, 1, 8'h55, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 1 byte in IDLE ignored
        addVec(0, 1, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 0); // 2 start
        addVec(0, 0, 1, 8'hAB, 0, 0, 16'h0000, 8'h00, 0, 1, 1, 0); // 3
        addVec(0, 0, 1, 8'hCD, 0, 0, 16'hABCD, 8'hBC, 1, 0, 2, 0); // 4 frame done
        addVec(0, 0, 0, 8'h00, 0, 0, 16'hABCD, 8'hBC, 1, 0, 2, 0); // 5 held
        addVec(0, 0, 0, 8'h00, 1, 0, 16'hABCD, 8'hBC, 0, 0, 0, 0); // 6 ack
        addVec(0, 0, 0, 8'h00, 1, 0, 16'hABCD, 8'hBC, 0, 0, 0, 0); // 7 ack in IDLE
        addVec(0, 1, 0, 8'h00, 0, 0, 16'hABCD, 8'hBC, 0, 1, 0, 0); // 8 start
        addVec(0, 0, 1, 8'h12, 0, 0, 16'hABCD, 8'hBC, 0, 1, 1, 0); // 9
        addVec(0, 1, 0, 8'h00, 0, 0, 16'hABCD, 8'hBC, 0, 1, 0, 0); // 10 abort
        addVec(0, 0, 1, 8'h34, 0, 0, 16'hABCD, 8'hBC, 0, 1, 1, 0); // 11
        addVec(0, 1, 1, 8'h99, 0, 0, 16'hABCD, 8'hBC, 0, 1, 0, 0); // 12 start beats byte
        addVec(0, 0, 1, 8'h34, 0, 0, 16'hABCD, 8'hBC, 0, 1, 1, 0); // 13
        addVec(0, 0, 1, 8'h56, 0, 0, 16'h3456, 8'h45, 1, 0, 2, 0); // 14
        addVec(0, 0, 1, 8'h77, 0, 0, 16'h3456, 8'h45, 1, 0, 2, 1); // 15 overrun
        addVec(0, 1, 0, 8'h00, 0, 0, 16'h3456, 8'h45, 1, 0, 2, 1); // 16 start in DONE ignored
        addVec(0, 0, 0, 8'h00, 0, 1, 16'h3456, 8'h45, 1, 0, 2, 0); // 17 clear
        addVec(0, 0, 1, 8'h88, 0, 1, 16'h3456, 8'h45, 1, 0, 2, 1); // 18 set beats clear
        addVec(0, 1, 0, 8'h00, 1, 0, 16'h3456, 8'h45, 0, 1, 0, 1); // 19 ack+start
        addVec(0, 0, 1, 8'h0F, 0, 0, 16'h3456, 8'h45, 0, 1, 1, 1); // 20
        addVec(0, 0, 1, 8'hF0, 0, 0, 16'h0FF0, 8'hFF, 1, 0, 2, 1); // 21
        addVec(0, 0, 0, 8'h00, 0, 1, 16'h0FF0, 8'hFF, 1, 0, 2, 0); // 22
        addVec(0, 0, 0, 8'h00, 1, 0, 16'h0FF0, 8'hFF, 0, 0, 0, 0); // 23
        addVec(0, 1, 0, 8'h00, 0, 0, 16'h0FF0, 8'hFF, 0, 1, 0, 0); // 24
        addVec(0, 0, 1, 8'h21, 0, 0, 16'h0FF0, 8'hFF, 0, 1, 1, 0); // 25
        addVec(1, 0, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 26 reset mid-frame
        addVec(0, 0, 1, 8'h22, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 27 ignored
        addVec(0, 0, 1, 8'h33, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 28 ignored
        addVec(0, 1, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 0); // 29
        addVec(0, 0, 1, 8'hAA, 0, 0, 16'h0000, 8'h00, 0, 1, 1, 0); // 30
        addVec(0, 0, 1, 8'hBB, 0, 0, 16'hAABB, 8'hAB, 1, 0, 2, 0); // 31
        addVec(1, 1, 1, 8'hCC, 1, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 32 reset overrides all
        addVec(0, 0, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0); // 33 no stray valid

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].bv, vecs[i].b, vecs[i].ak, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].expRaw, vecs[i].expWord,
                        vecs[i].expValid, vecs[i].expBusy, vecs[i].expCount, vecs[i].expOvr);
        end

        // Three-byte, LSB-first frame on the second instance.
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        checkWide("w3_reset", 24'h000000, 12'h000, 0, 0, 3'd0);
        applyStimulus(0, 1, 0, 8'h00, 0, 0);
        checkWide("w3_start", 24'h000000, 12'h000, 0, 1, 3'd0);
        applyStimulus(0, 0, 1, 8'h11, 0, 0);
        checkWide("w3_b0", 24'h000000, 12'h000, 0, 1, 3'd1);
        applyStimulus(0, 0, 1, 8'h22, 0, 0);
        checkWide("w3_b1", 24'h000000, 12'h000, 0, 1, 3'd2);
        applyStimulus(0, 0, 1, 8'h33, 0, 0);
        checkWide("w3_done", 24'h332211, 12'h211, 1, 0, 3'd3);
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
        checkWide("w3_ack", 24'h332211, 12'h211, 0, 0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_word_assembler.md
SPI_WORD_ASSEMBLER -- requirements
Module: spi_word_assembler

Interface
REQ-001 Parameter NBYTES, default 2, number of received bytes concatenated per frame (range 1..4).
REQ-002 Parameter OUT_W, default 8, width of the extracted output field.
REQ-003 Parameter SHIFT, default 4, LSB position of the extracted field within the assembled word.
REQ-004 Parameter MSB_FIRST, default 1, byte order: 1 = first byte lands in the most significant byte, 0 = first byte lands in the least significant byte.
REQ-005 clk_i  input  1  system clock; one clock domain.
REQ-006 reset_i  input  1  reset, synchronous and active-high.
REQ-007 start_i  input  1  single-cycle pulse that begins (or restarts) a frame.
REQ-008 byte_valid_i  input  1  qualifies byte_i for one cycle.
REQ-009 byte_i  input  8  received byte from the SPI shifter.
REQ-010 ack_i  input  1  consumer acknowledge of a completed frame.
REQ-011 clr_ovr_i  input  1  clears the sticky overrun flag.
REQ-012 raw_o  output  8*NBYTES  full assembled word of the last completed frame.
REQ-013 word_o  output  OUT_W  raw field [SHIFT+OUT_W-1:SHIFT] of the last completed frame.
REQ-014 valid_o  output  1  completed frame available, held until acknowledged.
REQ-015 busy_o  output  1  frame collection in progress.
REQ-016 count_o  output  3  bytes received in the current frame.
REQ-017 overrun_o  output  1  sticky: a byte arrived while a frame was pending acknowledge.

Function
REQ-018 Parameter check SHALL reject SHIFT+OUT_W > 8*NBYTES at elaboration.
REQ-019 FSM states IDLE, COLLECT, DONE; busy_o=1 only in COLLECT; valid_o=1 only in DONE.
REQ-020 IDLE: start_i -> COLLECT with count=0 and the internal assembly register cleared; byte_valid_i ignored.
REQ-021 COLLECT: each byte_valid_i cycle writes byte_i to slot count (MSB_FIRST=1: bits [8*(NBYTES-count)-1 -: 8]; else bits [8*count+7 -: 8]) and increments count.
REQ-022 COLLECT: byte_valid_i with count=NBYTES-1 -> DONE next cycle; in the same edge, raw_o loads the completed word including that byte and word_o loads its field.
REQ-023 Latency: valid_o asserts on the clock edge after the last byte_valid_i cycle.
REQ-024 COLLECT: start_i aborts the frame: count=0, assembly cleared, stay in COLLECT; when start_i and byte_valid_i coincide, start_i wins and the byte is dropped.
REQ-025 DONE: ack_i -> IDLE; ack_i and start_i in the same cycle -> COLLECT with count=0.
REQ-026 DONE: byte_valid_i without ack_i drops the byte and sets overrun_o; raw_o and word_o unchanged.
REQ-027 raw_o and word_o change only on frame completion; they hold between frames and through aborts.
REQ-028 overrun_o is cleared by clr_ovr_i; if set and clear coincide, set wins.
REQ-029 ack_i outside DONE and start_i in DONE without ack_i have no effect.
REQ-030 count_o reflects count in COLLECT, NBYTES in DONE, 0 in IDLE.

Reset
REQ-031 reset_i=1 at a clk_i edge forces IDLE, count=0, assembly=0, raw_o=0, word_o=0, valid_o=0, busy_o=0, overrun_o=0, and overrides all other inputs.
REQ-032 Reset in COLLECT or DONE discards the partial or pending frame; no valid_o pulse follows.

Verification
REQ-033 Defaults; start, bytes 0xAB then 0xCD -> raw_o=0xABCD, word_o=0xBC, valid_o high on the edge after 0xCD until ack_i.
REQ-034 MSB_FIRST=0, NBYTES=3, OUT_W=12, SHIFT=0; bytes 0x11,0x22,0x33 -> raw_o=0x332211, word_o=0x211.
REQ-035 Defaults; start, 0x12, start, 0x34, 0x56 -> raw_o=0x3456; earlier raw_o value held during abort.
REQ-036 DONE held without ack_i, byte 0x77 -> overrun_o=1, raw_o unchanged; clr_ovr_i -> overrun_o=0; simultaneous byte+clr -> overrun_o=1.
REQ-037 reset_i asserted after first byte -> all outputs 0; following bytes without start_i ignored.
REQ-038 ack_i and start_i together in DONE -> COLLECT, count_o=0, next two bytes complete a new frame.
